regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port between three writeback requesters: 0 = ALU, 1 = LSU, 2 = MUL/DIV.
- Uses round-robin arbitration and drives the port through registered outputs.
- Keeps a per-register pending-write scoreboard so decode can stall on RAW hazards.
- Sits between the execute/memory writeback sources and the regfile write port (we/waddr/wdata).

---
 rtl/regfile_wb_arbiter_if.sv | 19 +
 rtl/regfile_wb_arbiter.sv | 83 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus between the three result sources and the arbiter,
// plus the registered regfile write port the arbiter drives.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [2:0]          req_valid;
  logic [2:0]          req_ready;
  logic [3*ADDR_W-1:0] req_addr;
  logic [3*DATA_W-1:0] req_data;
  logic                wb_we;
  logic [ADDR_W-1:0]   wb_waddr;
  logic [DATA_W-1:0]   wb_wdata;

  modport master (output req_valid, req_addr, req_data,
                  input  req_ready, wb_we, wb_waddr, wb_wdata);
  modport slave  (input  req_valid, req_addr, req_data,
                  output req_ready, wb_we, wb_waddr, wb_wdata);
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the regfile write port (ALU/LSU/MDU) with a
// pending-write scoreboard that decode queries for RAW stalls.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic                clk,
  input  logic                rst,
  regfile_wb_arbiter_if.slave bus,
  input  logic                sb_set,
  input  logic [ADDR_W-1:0]   sb_set_addr,
  input  logic                flush,
  input  logic [ADDR_W-1:0]   sb_raddr1,
  output logic                sb_busy1,
  input  logic [ADDR_W-1:0]   sb_raddr2,
  output logic                sb_busy2,
  output logic                sb_any_busy,
  output logic                err_orphan
);
  logic [2:0][ADDR_W-1:0] addr_a;
  logic [2:0][DATA_W-1:0] data_a;
  logic [1:0]             ptr, ord1, ord2, gidx;
  logic                   any;
  logic [2:0]             grant;
  logic [ADDR_W-1:0]      sel_addr;
  logic                   wr_live;
  logic [NREG-1:0]        busy, busy_nxt;

  assign addr_a = bus.req_addr;
  assign data_a = bus.req_data;

  // Search order ptr, ptr+1, ptr+2 (mod 3); ptr only ever holds 0..2.
  assign ord1 = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
  assign ord2 = (ptr == 2'd0) ? 2'd2 : ptr - 2'd1;

  always_comb begin
    any  = 1'b1;
    gidx = ptr;
    if      (bus.req_valid[ptr])  gidx = ptr;
    else if (bus.req_valid[ord1]) gidx = ord1;
    else if (bus.req_valid[ord2]) gidx = ord2;
    else                          any  = 1'b0;
    grant = any ? (3'b001 << gidx) : 3'b000;
  end

  assign bus.req_ready = rst ? grant : 3'b000;
  assign sel_addr      = addr_a[gidx];
  assign wr_live       = any && (sel_addr != '0);

  // Flush beats everything; otherwise a new producer (set) beats retirement (clear).
  always_comb begin
    busy_nxt = busy;
    if (wr_live) busy_nxt[sel_addr] = 1'b0;
    if (flush)                                busy_nxt = '0;
    else if (sb_set && sb_set_addr != '0)     busy_nxt[sb_set_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr          <= 2'd0;
      busy         <= '0;
      bus.wb_we    <= 1'b0;
      bus.wb_waddr <= '0;
      bus.wb_wdata <= '0;
      err_orphan   <= 1'b0;
    end else begin
      busy       <= busy_nxt;
      bus.wb_we  <= wr_live;
      err_orphan <= wr_live && !busy[sel_addr];
      if (any) begin
        ptr          <= (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;
        bus.wb_waddr <= sel_addr;
        bus.wb_wdata <= data_a[gidx];
      end
    end
  end

  assign sb_busy1    = busy[sb_raddr1];
  assign sb_busy2    = busy[sb_raddr2];
  assign sb_any_busy = |busy;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a behavioural model.
module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sb_set = 1'b0;
  logic [AW-1:0] sb_set_addr = '0;
  logic          flush = 1'b0;
  logic [AW-1:0] sb_raddr1 = '0, sb_raddr2 = '0;
  logic          sb_busy1, sb_busy2, sb_any_busy, err_orphan;

  int total = 0;
  int passed = 0;

  regfile_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus();

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NREG(32)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .sb_set(sb_set), .sb_set_addr(sb_set_addr), .flush(flush),
    .sb_raddr1(sb_raddr1), .sb_busy1(sb_busy1),
    .sb_raddr2(sb_raddr2), .sb_busy2(sb_busy2),
    .sb_any_busy(sb_any_busy), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  // Reference model: pending set of registers, rr pointer, expected port values.
  bit [31:0]     m_busy;
  int            m_ptr;
  logic          e_we, e_orphan;
  logic [AW-1:0] e_waddr;
  logic [DW-1:0] e_wdata;
  int            last_g;

  function automatic void model_reset();
    m_busy = '0; m_ptr = 0; e_we = 0; e_orphan = 0; e_waddr = '0; e_wdata = '0; last_g = -1;
  endfunction

  function automatic int mgrant();
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (m_ptr + k) % 3;
      if (bus.req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [2:0] mready();
    int g;
    g = mgrant();
    return (g < 0) ? 3'b000 : 3'(1 << g);
  endfunction

  // Advance the model by one clock edge using the currently driven inputs, then step the DUT.
  task automatic tick();
    int g;
    logic [AW-1:0] a;
    a = '0;
    g = mgrant();
    last_g = g;
    if (g >= 0) begin
      a = bus.req_addr[g*AW +: AW];
      e_waddr = a;
      e_wdata = bus.req_data[g*DW +: DW];
      e_we = (a != 0);
      e_orphan = (a != 0) && !m_busy[a];
      m_ptr = (g + 1) % 3;
    end else begin
      e_we = 0; e_orphan = 0;
    end
    if (flush) m_busy = '0;
    else begin
      if (g >= 0 && a != 0) m_busy[a] = 1'b0;
      if (sb_set && sb_set_addr != 0) m_busy[sb_set_addr] = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.req_valid = 3'b000; sb_set = 0; flush = 0;
  endtask

  task automatic do_reset();
    rst = 0; idle();
    #3;
    model_reset();
    rst = 1;
  endtask

  task automatic mark(input logic [AW-1:0] a);
    sb_set = 1; sb_set_addr = a;
    tick();
    sb_set = 0;
  endtask

  task automatic test_reset();
    bus.req_valid = 3'b111; bus.req_addr = {5'd3, 5'd2, 5'd1}; bus.req_data = '1;
    sb_raddr1 = 5'd1;
    #8;
    total++; if (bus.wb_we !== 1'b0) $display("FAIL reset_we got %b exp 0", bus.wb_we); else passed++;
    total++; if (bus.wb_waddr !== '0) $display("FAIL reset_waddr got %0d exp 0", bus.wb_waddr); else passed++;
    total++; if (bus.wb_wdata !== '0) $display("FAIL reset_wdata got %h exp 0", bus.wb_wdata); else passed++;
    total++; if (bus.req_ready !== 3'b000) $display("FAIL reset_ready got %b exp 000", bus.req_ready); else passed++;
    total++; if (sb_any_busy !== 1'b0) $display("FAIL reset_any_busy got %b exp 0", sb_any_busy); else passed++;
    total++; if (err_orphan !== 1'b0) $display("FAIL reset_orphan got %b exp 0", err_orphan); else passed++;
    total++; if (sb_busy1 !== 1'b0) $display("FAIL reset_busy1 got %b exp 0", sb_busy1); else passed++;
    model_reset();
    rst = 1; #1;
    total++; if (bus.req_ready !== 3'b001) $display("FAIL reset_first_grant got %b exp 001", bus.req_ready); else passed++;
    idle();
  endtask

  task automatic test_single_write();
    mark(5'd5);
    sb_raddr1 = 5'd5;
    bus.req_valid = 3'b001; bus.req_addr = {5'd0, 5'd0, 5'd5}; bus.req_data = {64'd0, 32'hDEADBEEF};
    #1;
    total++; if (bus.req_ready !== 3'b001) $display("FAIL single_ready got %b exp 001", bus.req_ready); else passed++;
    total++; if (sb_busy1 !== 1'b1) $display("FAIL single_busy_before got %b exp 1", sb_busy1); else passed++;
    tick();
    idle();
    total++; if (sb_busy1 !== 1'b0) $display("FAIL single_busy_after got %b exp 0", sb_busy1); else passed++;
    total++; if (bus.wb_we !== 1'b1) $display("FAIL single_we got %b exp 1", bus.wb_we); else passed++;
    total++; if (bus.wb_waddr !== 5'd5) $display("FAIL single_waddr got %0d exp 5", bus.wb_waddr); else passed++;
    total++; if (bus.wb_wdata !== 32'hDEADBEEF) $display("FAIL single_wdata got %h exp deadbeef", bus.wb_wdata); else passed++;
    total++; if (err_orphan !== 1'b0) $display("FAIL single_orphan got %b exp 0", err_orphan); else passed++;
    tick();
    total++; if (bus.wb_we !== 1'b0) $display("FAIL single_we_drop got %b exp 0", bus.wb_we); else passed++;
  endtask

  task automatic test_round_robin();
    logic [2:0]    rr_g [4];
    logic [AW-1:0] rr_a [4];
    rr_g = '{3'b001, 3'b010, 3'b100, 3'b001};
    rr_a = '{5'd1, 5'd2, 5'd3, 5'd1};
    do_reset();
    mark(5'd1); mark(5'd2); mark(5'd3);
    bus.req_valid = 3'b111; bus.req_addr = {5'd3, 5'd2, 5'd1};
    bus.req_data = {32'h33333333, 32'h22222222, 32'h11111111};
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (bus.req_ready !== rr_g[k] || bus.req_ready !== mready())
        $display("FAIL rr_grant[%0d] got %b exp %b", k, bus.req_ready, rr_g[k]); else passed++;
      tick();
      total++; if (bus.wb_we !== 1'b1 || bus.wb_waddr !== rr_a[k] || bus.wb_wdata !== e_wdata)
        $display("FAIL rr_write[%0d] got we=%b addr=%0d data=%h exp addr=%0d data=%h", k, bus.wb_we, bus.wb_waddr, bus.wb_wdata, rr_a[k], e_wdata);
      else passed++;
      total++; if (err_orphan !== e_orphan) $display("FAIL rr_orphan[%0d] got %b exp %b", k, err_orphan, e_orphan); else passed++;
    end
    idle();
    tick();
  endtask

  task automatic test_reg0();
    bus.req_valid = 3'b010; bus.req_addr = '0; bus.req_data = {32'd0, 32'h1234, 32'd0};
    #1;
    total++; if (bus.req_ready !== mready() || bus.req_ready[1] !== 1'b1)
      $display("FAIL reg0_ready got %b exp %b", bus.req_ready, mready()); else passed++;
    tick();
    idle();
    total++; if (bus.wb_we !== 1'b0) $display("FAIL reg0_we got %b exp 0", bus.wb_we); else passed++;
    total++; if (err_orphan !== 1'b0) $display("FAIL reg0_orphan got %b exp 0", err_orphan); else passed++;
    total++; if (sb_any_busy !== (m_busy != 0)) $display("FAIL reg0_any_busy got %b exp %b", sb_any_busy, m_busy != 0); else passed++;
  endtask

  task automatic test_collision();
    do_reset();
    mark(5'd7);
    sb_raddr1 = 5'd7; sb_raddr2 = 5'd9;
    bus.req_valid = 3'b100; bus.req_addr = {5'd7, 5'd0, 5'd0}; bus.req_data = {32'h77, 64'd0};
    sb_set = 1; sb_set_addr = 5'd7;
    tick();
    total++; if (sb_busy1 !== 1'b1) $display("FAIL coll_same_busy7 got %b exp 1", sb_busy1); else passed++;
    total++; if (bus.wb_we !== 1'b1 || bus.wb_waddr !== 5'd7) $display("FAIL coll_same_write got we=%b addr=%0d exp 1/7", bus.wb_we, bus.wb_waddr); else passed++;
    total++; if (err_orphan !== 1'b0) $display("FAIL coll_same_orphan got %b exp 0", err_orphan); else passed++;
    sb_set_addr = 5'd9;
    tick();
    idle();
    total++; if (sb_busy2 !== 1'b1) $display("FAIL coll_diff_busy9 got %b exp 1", sb_busy2); else passed++;
    total++; if (sb_busy1 !== 1'b0) $display("FAIL coll_diff_busy7 got %b exp 0", sb_busy1); else passed++;
  endtask

  task automatic test_flush_orphan();
    do_reset();
    mark(5'd4); mark(5'd6);
    sb_raddr1 = 5'd8; sb_raddr2 = 5'd4;
    total++; if (sb_any_busy !== 1'b1) $display("FAIL flush_pre_any got %b exp 1", sb_any_busy); else passed++;
    flush = 1; sb_set = 1; sb_set_addr = 5'd8;
    tick();
    idle();
    total++; if (sb_any_busy !== 1'b0) $display("FAIL flush_any got %b exp 0", sb_any_busy); else passed++;
    total++; if (sb_busy1 !== 1'b0) $display("FAIL flush_busy8 got %b exp 0", sb_busy1); else passed++;
    bus.req_valid = 3'b001; bus.req_addr = {10'd0, 5'd4}; bus.req_data = {64'd0, 32'h44};
    tick();
    idle();
    total++; if (bus.wb_we !== 1'b1 || err_orphan !== 1'b1) $display("FAIL flush_orphan got we=%b orphan=%b exp 1/1", bus.wb_we, err_orphan); else passed++;
    tick();
    total++; if (err_orphan !== 1'b0) $display("FAIL flush_orphan_pulse got %b exp 0", err_orphan); else passed++;
  endtask

  task automatic test_async_reset();
    mark(5'd10);
    sb_raddr1 = 5'd10;
    bus.req_valid = 3'b010; bus.req_addr = {5'd0, 5'd3, 5'd0}; bus.req_data = {32'd0, 32'h33, 32'd0};
    tick();
    total++; if (bus.wb_we !== 1'b1) $display("FAIL areset_pre_we got %b exp 1", bus.wb_we); else passed++;
    bus.req_valid = 3'b111;
    #3 rst = 0;
    #1;
    total++; if (bus.wb_we !== 1'b0) $display("FAIL areset_we got %b exp 0", bus.wb_we); else passed++;
    total++; if (sb_any_busy !== 1'b0 || sb_busy1 !== 1'b0) $display("FAIL areset_busy got any=%b b1=%b exp 0/0", sb_any_busy, sb_busy1); else passed++;
    total++; if (bus.req_ready !== 3'b000) $display("FAIL areset_ready got %b exp 000", bus.req_ready); else passed++;
    model_reset();
    #2 rst = 1;
    #1;
    total++; if (bus.req_ready !== 3'b001) $display("FAIL areset_first_grant got %b exp 001", bus.req_ready); else passed++;
    idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!bus.req_valid[i] && $urandom_range(0, 1) == 1) begin
          bus.req_valid[i] = 1'b1;
          bus.req_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
          bus.req_data[i*DW +: DW] = $urandom;
        end
      end
      sb_set = ($urandom_range(0, 9) < 4);
      sb_set_addr = AW'($urandom_range(0, 7));
      flush = ($urandom_range(0, 19) == 0);
      sb_raddr1 = AW'($urandom_range(0, 7));
      sb_raddr2 = AW'($urandom_range(0, 7));
      #1;
      total++; if (bus.req_ready !== mready()) $display("FAIL rnd_ready[%0d] got %b exp %b", c, bus.req_ready, mready()); else passed++;
      total++; if (sb_busy1 !== m_busy[sb_raddr1] || sb_busy2 !== m_busy[sb_raddr2] || sb_any_busy !== (m_busy != 0))
        $display("FAIL rnd_busy[%0d] got %b%b%b exp %b%b%b", c, sb_busy1, sb_busy2, sb_any_busy, m_busy[sb_raddr1], m_busy[sb_raddr2], m_busy != 0);
      else passed++;
      tick();
      total++; if (bus.wb_we !== e_we || bus.wb_waddr !== e_waddr || bus.wb_wdata !== e_wdata)
        $display("FAIL rnd_port[%0d] got %b/%0d/%h exp %b/%0d/%h", c, bus.wb_we, bus.wb_waddr, bus.wb_wdata, e_we, e_waddr, e_wdata);
      else passed++;
      total++; if (err_orphan !== e_orphan) $display("FAIL rnd_orphan[%0d] got %b exp %b", c, err_orphan, e_orphan); else passed++;
      if (last_g >= 0) bus.req_valid[last_g] = 1'b0;
    end
    idle();
  endtask

  initial begin
    model_reset();
    bus.req_valid = 3'b000; bus.req_addr = '0; bus.req_data = '0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_reg0();
    test_collision();
    test_flush_orphan();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
